reg_sweeper: RTL and testbench

Parametrised register-index sequencer for the register-file write path. When armed by `go` it holds a start index, then on `go` release sweeps `len` consecutive indices up or down from that start, with a configurable stride, asserting a write strobe for each. It then parks in a done state until re-armed. It drives the register-number and write-enable inputs of the register file in the lab datapath, replacing the fixed-start, fixed-length four-step sequencer.

---
 rtl/reg_sweeper_pkg.sv | 14 +
 rtl/reg_sweeper_if.sv | 25 ++
 rtl/reg_sweeper_sweep_counter.sv | 49 ++++
 rtl/reg_sweeper.sv | 106 ++++++++++
 tb/tb_reg_sweeper.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/reg_sweeper_pkg.sv
// Shared types and constants for the register-index sweeper.
package reg_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/reg_sweeper_if.sv
// Control and register-file-side signals of the sweeper, grouped as one bus.
interface reg_sweeper_if #(
    parameter int REG_W = 5,
    parameter int LEN_W = 4
);
    logic             go;
    logic             direction;
    logic [REG_W-1:0] start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic [REG_W-1:0] regnum;
    logic             wr_en;
    logic             busy;
    logic             done;

    modport master (
        output go, direction, start, len, abort,
        input  regnum, wr_en, busy, done
    );

    modport slave (
        input  go, direction, start, len, abort,
        output regnum, wr_en, busy, done
    );
endinterface

// File: rtl/reg_sweeper_sweep_counter.sv
// Index register, step down-counter and latched sweep direction.
module sweep_counter
    import reg_sweeper_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int LEN_W  = 4,
    parameter int STRIDE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step_idx,
    input  logic             step_cnt,
    input  logic             dir_load,
    input  logic             dir_in,
    input  logic [REG_W-1:0] start,
    input  logic [LEN_W-1:0] len,
    output logic [REG_W-1:0] idx,
    output logic             last,
    output logic             empty
);
    localparam logic [REG_W-1:0] STRIDE_V = REG_W'(STRIDE);

    logic [LEN_W-1:0] cnt;
    logic             dir_q;
    logic             step_dir;

    // The first step happens in the same cycle the direction is captured,
    // so it must use the live input rather than the stored copy.
    assign step_dir = dir_load ? dir_in : dir_q;
    assign last     = (cnt == LEN_W'(1));
    assign empty    = (cnt == '0);

    // Index, counter and direction registers; index wraps modulo 2^REG_W.
    always_ff @(posedge clock) begin
        if (!reset) begin
            idx   <= '0;
            cnt   <= '0;
            dir_q <= DIR_UP;
        end else if (load) begin
            idx <= start;
            cnt <= len;
        end else begin
            if (dir_load) dir_q <= dir_in;
            if (step_idx) idx <= (step_dir == DIR_UP) ? idx + STRIDE_V : idx - STRIDE_V;
            if (step_cnt) cnt <= cnt - LEN_W'(1);
        end
    end
endmodule

// File: rtl/reg_sweeper.sv
// Register-index sweeper: FSM and output decode around sweep_counter.
//
//   state | meaning
//   IDLE  | reset state, waiting for go
//   ARMED | go held: start/len re-latched every cycle, no writes
//   SWEEP | one write strobe per cycle, index stepping by STRIDE
//   DONE  | sweep finished or aborted, last index held until re-armed
module reg_sweeper
    import reg_sweeper_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int LEN_W  = 4,
    parameter int STRIDE = 1
) (
    input  logic          clock,
    input  logic          reset,
    reg_sweeper_if.slave  bus
);
    state_t           state_q;
    state_t           state_d;
    logic             load;
    logic             step_idx;
    logic             step_cnt;
    logic             dir_load;
    logic [REG_W-1:0] idx;
    logic             last;
    logic             empty;

    sweep_counter #(
        .REG_W  (REG_W),
        .LEN_W  (LEN_W),
        .STRIDE (STRIDE)
    ) u_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .step_idx (step_idx),
        .step_cnt (step_cnt),
        .dir_load (dir_load),
        .dir_in   (bus.direction),
        .start    (bus.start),
        .len      (bus.len),
        .idx      (idx),
        .last     (last),
        .empty    (empty)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and counter controls; abort wins over go in ARMED.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step_idx = 1'b0;
        step_cnt = 1'b0;
        dir_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    load    = 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (bus.abort) begin
                    state_d = DONE;
                end else if (bus.go) begin
                    load = 1'b1;
                end else begin
                    dir_load = 1'b1;
                    if (empty) begin
                        state_d = DONE;
                    end else begin
                        step_idx = 1'b1;
                        state_d  = SWEEP;
                    end
                end
            end
            SWEEP: begin
                if (bus.abort) begin
                    state_d = DONE;
                end else begin
                    step_cnt = 1'b1;
                    if (last) state_d  = DONE;
                    else      step_idx = 1'b1;
                end
            end
            DONE: begin
                if (bus.go) begin
                    load    = 1'b1;
                    state_d = ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.regnum = idx;
    assign bus.wr_en  = (state_q == SWEEP);
    assign bus.busy   = (state_q == ARMED) || (state_q == SWEEP);
    assign bus.done   = (state_q == DONE);
endmodule

// File: tb/tb_reg_sweeper.sv
// Randomised bench for reg_sweeper: two instances (STRIDE 1 and 3) share
// stimulus and are checked against arithmetic expectations per sweep.
module tb_reg_sweeper;

    logic       clock = 1'b0;
    logic       reset;
    logic       go;
    logic       direction;
    logic       abort;
    logic [4:0] start;
    logic [3:0] len;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    reg_sweeper_if #(.REG_W(5), .LEN_W(4)) bus1 ();
    reg_sweeper_if #(.REG_W(5), .LEN_W(4)) bus3 ();

    assign bus1.go = go;
    assign bus1.direction = direction;
    assign bus1.abort = abort;
    assign bus1.start = start;
    assign bus1.len = len;
    assign bus3.go = go;
    assign bus3.direction = direction;
    assign bus3.abort = abort;
    assign bus3.start = start;
    assign bus3.len = len;

    reg_sweeper #(.REG_W(5), .LEN_W(4), .STRIDE(1)) u_s1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    reg_sweeper #(.REG_W(5), .LEN_W(4), .STRIDE(3)) u_s3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got {regnum,wr,busy,done}=%h expected %h", tag, got, exp);
        end
    endtask

    // Index after i steps of size stride from s, modulo 32.
    function automatic logic [4:0] idx_at(input int s, input bit d, input int i, input int stride);
        int v;
        v = s + (d ? i * stride : -(i * stride));
        v = v % 32;
        if (v < 0) v += 32;
        return 5'(v);
    endfunction

    task automatic expect_out(input string tag, input logic [4:0] r1, input logic [4:0] r3,
                              input bit wr, input bit bsy, input bit dn);
        check({tag, "/s1"}, {bus1.regnum, bus1.wr_en, bus1.busy, bus1.done}, {r1, wr, bsy, dn});
        check({tag, "/s3"}, {bus3.regnum, bus3.wr_en, bus3.busy, bus3.done}, {r3, wr, bsy, dn});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One arm/sweep transaction. abort_cyc: 0 none, -1 abort in ARMED,
    // k>0 abort during sweep cycle k. rst_cyc: reset low during sweep cycle k.
    task automatic run_sweep(input string name, input int s, input int n, input bit d,
                             input int hold, input int abort_cyc, input int rst_cyc);
        logic [4:0] e1;
        logic [4:0] e3;
        reset = 1'b1;
        abort = 1'b0;
        for (int h = 0; h < hold; h++) begin
            go        = 1'b1;
            direction = 1'($urandom_range(0, 1));
            if (h == hold - 1) begin
                start = 5'(s);
                len   = 4'(n);
            end else begin
                start = 5'($urandom);
                len   = 4'($urandom);
            end
            tick();
            expect_out({name, ":armed"}, start, start, 1'b0, 1'b1, 1'b0);
        end
        go        = 1'b0;
        direction = d;
        start     = 5'($urandom);
        len       = 4'($urandom);
        if (abort_cyc < 0) begin
            abort = 1'b1;
            tick();
            expect_out({name, ":arm_abort"}, 5'(s), 5'(s), 1'b0, 1'b0, 1'b1);
            abort = 1'b0;
            tick();
            expect_out({name, ":arm_abort_hold"}, 5'(s), 5'(s), 1'b0, 1'b0, 1'b1);
            return;
        end
        tick();
        for (int i = 1; i <= n; i++) begin
            e1 = idx_at(s, d, i, 1);
            e3 = idx_at(s, d, i, 3);
            expect_out({name, ":sweep"}, e1, e3, 1'b1, 1'b1, 1'b0);
            direction = ~direction;
            go        = 1'($urandom_range(0, 1));
            start     = 5'($urandom);
            len       = 4'($urandom);
            abort     = (i == abort_cyc);
            reset     = (i != rst_cyc);
            tick();
            if (i == rst_cyc) begin
                expect_out({name, ":reset"}, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
                reset = 1'b1;
                go    = 1'b0;
                tick();
                expect_out({name, ":idle"}, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (i == abort_cyc) begin
                expect_out({name, ":abort"}, e1, e3, 1'b0, 1'b0, 1'b1);
                abort = 1'b0;
                go    = 1'b0;
                tick();
                expect_out({name, ":abort_hold"}, e1, e3, 1'b0, 1'b0, 1'b1);
                return;
            end
        end
        e1 = idx_at(s, d, n, 1);
        e3 = idx_at(s, d, n, 3);
        expect_out({name, ":done"}, e1, e3, 1'b0, 1'b0, 1'b1);
        go = 1'b0;
        for (int k = 0; k < 2; k++) begin
            abort = 1'($urandom_range(0, 1));
            tick();
            expect_out({name, ":done_hold"}, e1, e3, 1'b0, 1'b0, 1'b1);
        end
        abort = 1'b0;
    endtask

    initial begin
        int s;
        int n;
        int h;
        int ab;
        bit d;
        reset     = 1'b0;
        go        = 1'b0;
        abort     = 1'b0;
        direction = 1'b0;
        start     = 5'd0;
        len       = 4'd0;
        tick();
        tick();
        expect_out("reset", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        expect_out("idle", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        run_sweep("up8",      8, 4, 1'b1, 1,  0, 0);
        run_sweep("down8",    8, 4, 1'b0, 1,  0, 0);
        run_sweep("wrap_up", 30, 4, 1'b1, 1,  0, 0);
        run_sweep("wrap_dn",  1, 2, 1'b0, 1,  0, 0);
        run_sweep("len0",    17, 0, 1'b1, 3,  0, 0);
        run_sweep("rearm",    3, 3, 1'b0, 4,  0, 0);
        run_sweep("rst_mid",  5, 6, 1'b1, 1,  0, 2);
        run_sweep("abort3",  12, 5, 1'b1, 1,  3, 0);
        run_sweep("hold10",  20, 7, 1'b0, 10, 0, 0);
        run_sweep("arm_abt",  9, 5, 1'b1, 2, -1, 0);
        run_sweep("max_len",  0, 15, 1'b0, 1, 0, 0);

        for (int t = 0; t < 25; t++) begin
            s  = $urandom_range(0, 31);
            n  = $urandom_range(0, 15);
            d  = 1'($urandom_range(0, 1));
            h  = $urandom_range(1, 4);
            ab = 0;
            if (n > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, n);
            run_sweep("rand", s, n, d, h, ab, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
